// File: rtl/pipe_pkg.sv
// Shared opcode constants and the per-stage control bundle for pipe_ctrl.
// PIPE_CTRL_MEXT_EN adds the multiply-enable field to the bundle.
package pipe_pkg;

  // The bundle carries rd at this width. Each module uses its own low RA_W bits, so RA_W must not exceed it.
  localparam int RA_W_MAX = 8;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
`ifdef PIPE_CTRL_MEXT_EN
    logic                mul;
`endif
    logic                sub;
    logic                imm;
    logic                jmp;
    logic                br;
    logic                lw;
    logic                sw;
    logic                wr;
    logic [RA_W_MAX-1:0] rd;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID decode: opcode/function fields -> ctrl_t bundle plus source-use flags.
// PIPE_CTRL_MEXT_EN: R-type with funct7=0000001 decodes as multiply.
module ctrl_decode
  import pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            id_valid,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [RA_W-1:0] rd,
  output ctrl_t           ctrl,
  output logic            use_rs1,
  output logic            use_rs2
);

  // funct3 takes no part in this control decode.
  logic unused_funct;
  assign unused_funct = ^{funct3, funct7};

  always_comb begin
    ctrl    = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (id_valid) begin
      case (op)
        OP_R: begin
          ctrl.wr  = 1'b1;
          ctrl.sub = funct7[5];
          use_rs1  = 1'b1;
          use_rs2  = 1'b1;
`ifdef PIPE_CTRL_MEXT_EN
          if (funct7 == F7_MUL) begin
            ctrl.mul = 1'b1;
            ctrl.sub = 1'b0;
          end
`endif
        end
        OP_I: begin
          ctrl.wr  = 1'b1;
          ctrl.imm = 1'b1;
          use_rs1  = 1'b1;
        end
        OP_JAL: begin
          ctrl.wr  = 1'b1;
          ctrl.jmp = 1'b1;
        end
        OP_JALR: begin
          ctrl.wr  = 1'b1;
          ctrl.jmp = 1'b1;
          use_rs1  = 1'b1;
        end
        OP_BR: begin
          ctrl.br = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
        OP_LW: begin
          ctrl.wr = 1'b1;
          ctrl.lw = 1'b1;
          use_rs1 = 1'b1;
        end
        OP_SW: begin
          ctrl.sw = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
        default: ;
      endcase
    end
    if (ctrl.wr) ctrl.rd = RA_W_MAX'(rd);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: ID decode, EX / MEM_STAGES x MEM / WB bundle registers, redirect and load-use hazard.
// Optional `PIPE_CTRL_MEXT_EN adds the ex_mul_en output.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int MEM_STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [RA_W-1:0] rd,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic            id_valid,
  input  logic            stall,
  input  logic            pass,
  output logic            ex_sub_en,
  output logic            ex_imm_en,
  output logic            mem_lw_en,
  output logic            mem_sw_en,
  output logic            wb_wr_en,
  output logic [RA_W-1:0] wb_rd,
  output logic            redirect,
`ifdef PIPE_CTRL_MEXT_EN
  output logic            ex_mul_en,
`endif
  output logic            lu_stall
);

  // Flow control: id_valid marks ID as holding a real instruction. While stall or lu_stall is high,
  // upstream keeps PC and IF/ID unchanged, and the same instruction is presented again next cycle.
  ctrl_t id_ctrl;
  logic  use_rs1;
  logic  use_rs2;

  ctrl_decode #(.RA_W(RA_W)) u_decode (
    .id_valid (id_valid),
    .op       (op),
    .funct3   (funct3),
    .funct7   (funct7),
    .rd       (rd),
    .ctrl     (id_ctrl),
    .use_rs1  (use_rs1),
    .use_rs2  (use_rs2)
  );

  ctrl_t ex_q, ex_d;
  ctrl_t mem_q [MEM_STAGES];
  ctrl_t mem_d [MEM_STAGES];
  ctrl_t wb_q, wb_d;
  logic  lu_raw;

  assign lu_raw = ex_q.lw && (ex_q.rd != '0) &&
                  ((use_rs1 && (ex_q.rd == RA_W_MAX'(rs1))) ||
                   (use_rs2 && (ex_q.rd == RA_W_MAX'(rs2))));

  assign redirect = ex_q.jmp | (ex_q.br & pass);
  assign lu_stall = lu_raw & ~redirect;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!stall) begin
      wb_d     = mem_q[MEM_STAGES-1];
      mem_d[0] = ex_q;
      for (int i = 1; i < MEM_STAGES; i++) mem_d[i] = mem_q[i-1];
      ex_d = (redirect || lu_raw) ? ctrl_t'('0) : id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
      for (int i = 0; i < MEM_STAGES; i++) mem_q[i] <= '0;
      wb_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_sub_en = ex_q.sub;
  assign ex_imm_en = ex_q.imm;
  assign mem_lw_en = mem_q[MEM_STAGES-1].lw;
  assign mem_sw_en = mem_q[MEM_STAGES-1].sw;
  assign wb_wr_en  = wb_q.wr;
  assign wb_rd     = wb_q.rd[RA_W-1:0];
`ifdef PIPE_CTRL_MEXT_EN
  assign ex_mul_en = ex_q.mul;
`endif

  // The WB bundle travels whole, but only wr/rd leave the block.
  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule
